conv_window_feeder: RTL and testbench

- Streaming producer for the dual 3x3 convolution stage: accepts a raster-order 8-bit pixel stream and emits 96-bit image windows (3 rows x 4 pixels).
- Each window feeds two horizontally adjacent 3x3 convolutions, at column c and column c+1.
- Valid-padding, stride-1 output coverage; each window advances 2 columns.
- Sits between the pixel source (DMA/camera front end) and the CBS convolution block.

---
 rtl/conv_pkg.sv | 37 +++
 rtl/conv_line_buffer.sv | 24 ++
 rtl/conv_window_feeder.sv | 111 +++++++++++
 tb/tb_conv_window_feeder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the dual 3x3 convolution window feeder: pixel/window
// geometry, FSM states, column type and the window packing helper.
package conv_pkg;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned WIN_ROWS = 3;
  localparam int unsigned WIN_COLS = 4;
  localparam int unsigned ROW_W    = PIX_W * WIN_COLS;
  localparam int unsigned WIN_W    = ROW_W * WIN_ROWS;

  localparam int unsigned TOP_LSB = 2 * ROW_W;
  localparam int unsigned MID_LSB = ROW_W;
  localparam int unsigned BOT_LSB = 0;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [PIX_W-1:0] top;
    logic [PIX_W-1:0] mid;
    logic [PIX_W-1:0] bot;
  } column_t;

  // c0 is the leftmost column; it lands in the MSB byte of every row.
  function automatic logic [WIN_W-1:0] pack_window(input column_t c0, input column_t c1,
                                                   input column_t c2, input column_t c3);
    logic [WIN_W-1:0] w;
    w = '0;
    w[TOP_LSB +: ROW_W] = {c0.top, c1.top, c2.top, c3.top};
    w[MID_LSB +: ROW_W] = {c0.mid, c1.mid, c2.mid, c3.mid};
    w[BOT_LSB +: ROW_W] = {c0.bot, c1.bot, c2.bot, c3.bot};
    return w;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Single-port row memory, DEPTH x PIX_W, asynchronous read so the old
// contents are seen in the same cycle they are overwritten.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Raster pixel stream to 3x4 window producer for the dual 3x3 convolution stage.
// Optional `CONV_WINDOW_COORD_EN adds m_row/m_col window top-left outputs.
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [PIX_W-1:0]         s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIN_W-1:0]         m_img,
`ifdef CONV_WINDOW_COORD_EN
  output logic [$clog2(IMG_H)-1:0] m_row,
  output logic [$clog2(IMG_W)-1:0] m_col,
`endif
  output logic                     m_last
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  generate
    if ((IMG_W % 2) != 0 || IMG_W < 4) begin : g_bad_img_w
      $error("conv_window_feeder: IMG_W must be even and >= 4");
    end
    if (IMG_H < 3) begin : g_bad_img_h
      $error("conv_window_feeder: IMG_H must be >= 3");
    end
  endgenerate

  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  state_t           state;
  column_t [2:0]    sr;
  column_t          new_col;
  logic [PIX_W-1:0] lb0_q, lb1_q;
  logic             accept, gen, x_last, y_last;

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;
  assign x_last  = (x == XW'(IMG_W - 1));
  assign y_last  = (y == YW'(IMG_H - 1));
  assign new_col = '{top: lb1_q, mid: lb0_q, bot: s_data};
  assign gen     = accept && (state == RUN) && x[0] && (x >= XW'(3));

  conv_line_buffer #(.DEPTH(IMG_W)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (x),
    .wdata (s_data),
    .rdata (lb0_q)
  );

  conv_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (x),
    .wdata (lb0_q),
    .rdata (lb1_q)
  );

  // Only the three older columns are stored; the incoming column completes
  // the 4-wide window combinationally, so sr[2] is the leftmost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x     <= '0;
      y     <= '0;
      state <= FILL;
      sr    <= '0;
    end else if (accept) begin
      sr <= {sr[1:0], new_col};
      x  <= x_last ? '0 : x + 1'b1;
      if (x_last) y <= y_last ? '0 : y + 1'b1;
      if (state == FILL && x_last && y == YW'(1)) state <= RUN;
      else if (state == RUN && x_last && y_last)  state <= FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_img   <= '0;
      m_last  <= 1'b0;
    end else if (gen) begin
      m_valid <= 1'b1;
      m_img   <= pack_window(sr[2], sr[1], sr[0], new_col);
      m_last  <= x_last && y_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

`ifdef CONV_WINDOW_COORD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_row <= '0;
      m_col <= '0;
    end else if (gen) begin
      m_row <= y - YW'(2);
      m_col <= x - XW'(3);
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench for conv_window_feeder (IMG_W=8, IMG_H=4): directed
// frames with pixel = 8*y+x plus randomized frames, checked against a window model.
module tb_conv_window_feeder;
  import conv_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned H = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIN_W-1:0] m_img;
  logic             m_last;
`ifdef CONV_WINDOW_COORD_EN
  logic [$clog2(H)-1:0] m_row;
  logic [$clog2(W)-1:0] m_col;
`endif

  conv_window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_img   (m_img),
`ifdef CONV_WINDOW_COORD_EN
    .m_row   (m_row),
    .m_col   (m_col),
`endif
    .m_last  (m_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIN_W-1:0] img;
    logic             last;
    int unsigned      row;
    int unsigned      col;
  } win_t;

  win_t        exp_q[$];
  logic [7:0]  frame [H][W];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned last_seen = 0;
  bit          rdy_rand = 0;
  logic        rdy_force = 1'b1;

  localparam logic [WIN_W-1:0] WIN_FIRST  = 96'h00010203_08090A0B_10111213;
  localparam logic [WIN_W-1:0] WIN_SECOND = 96'h02030405_0A0B0C0D_12131415;
  localparam logic [WIN_W-1:0] WIN_SIXTH  = 96'h0C0D0E0F_14151617_1C1D1E1F;

  task automatic check(input string tag, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: a window exists for every top-left (r, c) with c even, in raster order.
  task automatic load_frame(input bit directed);
    win_t e;
    for (int yy = 0; yy < int'(H); yy++)
      for (int xx = 0; xx < int'(W); xx++)
        frame[yy][xx] = directed ? 8'(yy * int'(W) + xx) : 8'($urandom);
    for (int r = 0; r + 3 <= int'(H); r++)
      for (int c = 0; c + 4 <= int'(W); c += 2) begin
        e.img = '0;
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 4; cc++)
            e.img = {e.img[WIN_W-9:0], frame[r+rr][c+cc]};
        e.last = (r == int'(H) - 3) && (c == int'(W) - 4);
        e.row  = r;
        e.col  = c;
        exp_q.push_back(e);
      end
  endtask

  function automatic logic makes_window(input int unsigned p);
    int unsigned xx, yy;
    xx = p % W;
    yy = p / W;
    return (yy >= 2) && (xx % 2 == 1) && (xx >= 3);
  endfunction

  // Called and returns just after a falling edge; all input changes happen there.
  task automatic put(input logic [7:0] d);
    logic acc;
    int unsigned guard;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 1000) begin
      s_valid = rdy_rand ? ($urandom_range(3) != 0) : 1'b1;
      s_data  = d;
      m_ready = rdy_rand ? ($urandom_range(2) != 0) : rdy_force;
      #1;
      acc = s_valid && s_ready;
      @(negedge clk);
      #1;
      guard++;
    end
    s_valid = 1'b0;
    check("px_accepted", acc, 1'b1);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      m_ready = rdy_rand ? ($urandom_range(2) != 0) : rdy_force;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input bit chk_valid);
    for (int unsigned p = 0; p < W * H; p++) begin
      put(frame[p / W][p % W]);
      if (chk_valid) check("valid_after_px", m_valid, makes_window(p));
    end
  endtask

  // Transfer monitor: samples well after the falling edge, when inputs are settled.
  logic             hold_prev = 1'b0;
  logic [WIN_W-1:0] prev_img;
  logic             prev_last;
  always @(negedge clk) begin
    win_t e;
    #3;
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_img", m_img, prev_img);
        check("hold_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        check("win_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("win_img", m_img, e.img);
          check("win_last", m_last, e.last);
`ifdef CONV_WINDOW_COORD_EN
          check("win_row", m_row, e.row);
          check("win_col", m_col, e.col);
`endif
          if (m_last) last_seen++;
        end
      end
      hold_prev = m_valid && !m_ready;
      prev_img  = m_img;
      prev_last = m_last;
    end
  end

  initial begin
    int unsigned ls0;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", m_valid, 1'b0);
    check("rst_img", m_img, '0);
    check("rst_last", m_last, 1'b0);
    check("rst_sready", s_ready, 1'b1);
`ifdef CONV_WINDOW_COORD_EN
    check("rst_row", m_row, '0);
    check("rst_col", m_col, '0);
`endif
    rst_n = 1'b1;
    idle(1);

    // First window, back-pressure, then reset mid-frame after pixel 20.
    load_frame(1);
    for (int unsigned p = 0; p < 20; p++) begin
      put(frame[p / W][p % W]);
      check("valid_fill", m_valid, makes_window(p));
    end
    check("first_win", m_img, WIN_FIRST);
    check("first_last", m_last, 1'b0);
    rdy_force = 1'b0;
    m_ready   = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("bp_sready", s_ready, 1'b0);
      check("bp_valid", m_valid, 1'b1);
      check("bp_img", m_img, WIN_FIRST);
    end
    rdy_force = 1'b1;
    put(frame[2][4]);
    check("px20_valid", m_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", m_valid, 1'b0);
    check("midrst_img", m_img, '0);
    exp_q.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Full directed frame after reset.
    load_frame(1);
    for (int unsigned p = 0; p < W * H; p++) begin
      put(frame[p / W][p % W]);
      check("valid_after_px", m_valid, makes_window(p));
      if (p == 19) check("restart_first_win", m_img, WIN_FIRST);
      if (p == 21) check("second_win", m_img, WIN_SECOND);
      if (p == W * H - 1) begin
        check("sixth_win", m_img, WIN_SIXTH);
        check("sixth_last", m_last, 1'b1);
`ifdef CONV_WINDOW_COORD_EN
        check("sixth_row", m_row, 1);
        check("sixth_col", m_col, 4);
`endif
      end
    end
    idle(4);
    check("frame_drained", exp_q.size(), 0);

    // Back-to-back frames with s_valid held high.
    ls0 = last_seen;
    load_frame(1);
    load_frame(1);
    send_frame(1);
    send_frame(1);
    idle(4);
    check("b2b_last_count", last_seen - ls0, 2);
    check("b2b_drained", exp_q.size(), 0);

    // Random data with random valid/ready gaps.
    rdy_rand = 1;
    for (int f = 0; f < 6; f++) begin
      load_frame(0);
      send_frame(0);
    end
    rdy_rand  = 0;
    rdy_force = 1'b1;
    idle(10);
    check("final_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
